// File: rtl/udp_payload_packetizer.sv
// Packs return-FIFO bytes into frames of 4-byte records and flushes idle frames with a 4-byte 0x00 NOP record.
// Macro PKTZ_SEQ_HDR_EN (optional) prefixes each frame with a big-endian 32-bit sequence number.
module udp_payload_packetizer #(
  parameter int MAX_PAYLOAD  = 64,
  parameter int IDLE_TIMEOUT = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifo_tdata,
  input  logic        fifo_tvalid,
  output logic        fifo_rd_en,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] frame_count
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_PAYLOAD);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_PAYLOAD - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

`ifdef PKTZ_SEQ_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, PAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] data_cnt, data_cnt_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic [2:0]    sub_cnt, sub_cnt_nxt;
  logic          pop, ld_vld, ld_last;
  logic [7:0]    ld_dat;
  logic          load, last_fire;

`ifdef PKTZ_SEQ_HDR_EN
  logic [31:0] seq_num;
  logic [31:0] hdr_word;
  assign hdr_word = seq_num << {sub_cnt[1:0], 3'b000};
`endif

  assign load       = !m_axis_tvalid || m_axis_tready;
  assign last_fire  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign fifo_rd_en = pop && !rst;

  always_comb begin
    state_nxt    = state;
    data_cnt_nxt = data_cnt;
    idle_cnt_nxt = idle_cnt;
    sub_cnt_nxt  = sub_cnt;
    pop          = 1'b0;
    ld_vld       = 1'b0;
    ld_dat       = 8'h00;
    ld_last      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_tvalid) begin
          data_cnt_nxt = '0;
          idle_cnt_nxt = '0;
          sub_cnt_nxt  = '0;
`ifdef PKTZ_SEQ_HDR_EN
          state_nxt = HDR;
`else
          state_nxt = DATA;
`endif
        end
      end
`ifdef PKTZ_SEQ_HDR_EN
      HDR: begin
        // sub_cnt==4 with load set means the 4th header byte has been taken
        if (load) begin
          if (sub_cnt == 3'd4) begin
            state_nxt   = DATA;
            sub_cnt_nxt = '0;
          end else begin
            ld_vld      = 1'b1;
            ld_dat      = hdr_word[31:24];
            sub_cnt_nxt = sub_cnt + 3'd1;
          end
        end
      end
`endif
      DATA: begin
        if (last_fire) begin
          state_nxt = IDLE;
        end else if (fifo_tvalid && load && data_cnt < CNT_MAX) begin
          pop          = 1'b1;
          ld_vld       = 1'b1;
          ld_dat       = fifo_tdata;
          ld_last      = (data_cnt == CNT_LAST);
          data_cnt_nxt = data_cnt + CW'(1);
          idle_cnt_nxt = '0;
        end else if (!fifo_tvalid && data_cnt != '0 && data_cnt[1:0] == 2'b00
                     && data_cnt < CNT_MAX) begin
          // only whole records may be closed by the timeout
          if (idle_cnt == IDLE_LAST) begin
            state_nxt    = PAD;
            idle_cnt_nxt = '0;
            sub_cnt_nxt  = '0;
          end else begin
            idle_cnt_nxt = idle_cnt + IW'(1);
          end
        end
      end
      PAD: begin
        if (last_fire) begin
          state_nxt = IDLE;
        end else if (load && sub_cnt < 3'd4) begin
          ld_vld      = 1'b1;
          ld_last     = (sub_cnt == 3'd3);
          sub_cnt_nxt = sub_cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      data_cnt      <= '0;
      idle_cnt      <= '0;
      sub_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= 8'h00;
      frame_count   <= 16'h0000;
`ifdef PKTZ_SEQ_HDR_EN
      seq_num       <= 32'h0;
`endif
    end else begin
      state    <= state_nxt;
      data_cnt <= data_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      sub_cnt  <= sub_cnt_nxt;
      if (load) begin
        m_axis_tvalid <= ld_vld;
        m_axis_tdata  <= ld_dat;
        m_axis_tlast  <= ld_last;
      end
      if (last_fire) begin
        frame_count <= frame_count + 16'd1;
`ifdef PKTZ_SEQ_HDR_EN
        seq_num     <= seq_num + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_packetizer.sv
// Bench for udp_payload_packetizer (default build): FIFO model, randomized backpressure/gaps, frame-level reference model.
module tb_udp_payload_packetizer;

  localparam int MAXP = 16;
  localparam int TO   = 8;
  localparam int LONG_GAP = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fifo_tdata = 8'h00;
  logic        fifo_tvalid = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  udp_payload_packetizer #(.MAX_PAYLOAD(MAXP), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .fifo_tdata(fifo_tdata), .fifo_tvalid(fifo_tvalid), .fifo_rd_en(fifo_rd_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .frame_count(frame_count)
  );

  int          errors = 0, checks = 0;
  int          plan[$];
  logic [7:0]  fq[$];
  logic [7:0]  exp_dat[$];
  logic        exp_last[$];
  int          model_n = 0;
  int          gcnt = -1;
  logic [15:0] exp_fc = 16'h0;
  int          pushed = 0, popped_n = 0;
  int          mode = 0;
  logic        prev_stall = 1'b0, prev_last = 1'b0, pend = 1'b0;
  logic [7:0]  prev_dat = 8'h00, pend_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: frames close after MAXP data bytes; a long empty gap at a
  // record boundary of an open frame appends a 00 00 00 00 record.
  function automatic void model_byte(input logic [7:0] b);
    exp_dat.push_back(b);
    exp_last.push_back(model_n == MAXP - 1);
    model_n = (model_n + 1) % MAXP;
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    plan.push_back(int'(b));
    model_byte(b);
  endfunction

  function automatic void add_gap(input int g);
    plan.push_back(1000 + g);
    if (g >= 12 && model_n > 0 && model_n % 4 == 0) begin
      for (int i = 0; i < 4; i++) begin
        exp_dat.push_back(8'h00);
        exp_last.push_back(i == 3);
      end
      model_n = 0;
    end
  endfunction

  // A gap item waits for the FIFO to drain, then holds it empty g cycles.
  function automatic void feeder();
    while (plan.size() > 0) begin
      if (plan[0] < 1000) begin
        fq.push_back(8'(plan[0]));
        pushed++;
        void'(plan.pop_front());
      end else begin
        if (fq.size() != 0) break;
        if (gcnt < 0) gcnt = plan[0] - 1000;
        if (gcnt == 0) begin
          void'(plan.pop_front());
          gcnt = -1;
        end else begin
          gcnt--;
          break;
        end
      end
    end
  endfunction

  task automatic drive();
    fifo_tvalid = (fq.size() != 0);
    fifo_tdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    case (mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 99) < 65);
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  task automatic step();
    logic popped;
    @(negedge clk);
    if (pend) begin
      chk("pop_to_out_valid", m_axis_tvalid, 1);
      chk("pop_to_out_data", m_axis_tdata, pend_byte);
    end
    if (prev_stall) begin
      chk("hold_valid", m_axis_tvalid, 1);
      chk("hold_data", m_axis_tdata, prev_dat);
      chk("hold_last", m_axis_tlast, prev_last);
    end
    if (m_axis_tvalid && !m_axis_tready) chk("rd_en_in_stall", fifo_rd_en, 0);
    if (m_axis_tvalid && m_axis_tready) begin
      chk("exp_avail", exp_dat.size() != 0, 1);
      if (exp_dat.size() != 0) begin
        chk("data", m_axis_tdata, exp_dat[0]);
        chk("last", m_axis_tlast, exp_last[0]);
        if (exp_last[0]) exp_fc++;
        void'(exp_dat.pop_front());
        void'(exp_last.pop_front());
      end
    end
    popped = fifo_rd_en;
    if (popped) chk("rd_en_nonempty", fq.size() != 0, 1);
    pend       = popped && (fq.size() != 0);
    pend_byte  = (fq.size() != 0) ? fq[0] : 8'h00;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_dat   = m_axis_tdata;
    prev_last  = m_axis_tlast;
    @(posedge clk);
    #1;
    if (pend) begin
      void'(fq.pop_front());
      popped_n++;
    end
    feeder();
    drive();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((plan.size() != 0 || fq.size() != 0 || exp_dat.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    chk($sformatf("%s_drained", name),
        (plan.size() == 0 && fq.size() == 0 && exp_dat.size() == 0), 1);
    repeat (30) step();
    chk($sformatf("%s_frame_count", name), frame_count, exp_fc);
    chk($sformatf("%s_pop_count", name), popped_n, pushed);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    chk("rd_en_in_reset", fifo_rd_en, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_dat.delete();
    exp_last.delete();
    model_n = 0;
    exp_fc = 16'h0;
    foreach (fq[i]) model_byte(fq[i]);
    drive();
  endtask

  initial begin
    int start, n;
    drive();
    do_reset();

    // one full frame 01..10
    mode = 0;
    for (int b = 1; b <= 16; b++) add_byte(8'(b));
    add_gap(LONG_GAP);
    drain("full_frame");

    // single record then idle -> NOP pad
    add_byte(8'hAA); add_byte(8'hBB); add_byte(8'hCC); add_byte(8'hDD);
    add_gap(LONG_GAP);
    drain("timeout_pad");

    // 5-cycle downstream stall mid-frame
    for (int b = 0; b < 16; b++) add_byte(8'($urandom_range(0, 255)));
    add_gap(LONG_GAP);
    repeat (6) step();
    mode = 2;
    repeat (5) step();
    mode = 0;
    drain("stall");

    // partial record never times out
    add_byte(8'h11); add_byte(8'h22);
    add_gap(LONG_GAP);
    add_byte(8'h33); add_byte(8'h44);
    add_gap(LONG_GAP);
    drain("partial_wait");

    // randomized records, gaps and backpressure
    mode = 1;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 4; k++) begin
        add_byte(8'($urandom_range(0, 255)));
        if (k == 1 && $urandom_range(0, 4) == 0)
          add_gap(($urandom_range(0, 1) == 1) ? LONG_GAP : int'($urandom_range(0, 3)));
      end
      add_gap(($urandom_range(0, 3) == 0) ? LONG_GAP : int'($urandom_range(0, 3)));
    end
    add_gap(LONG_GAP);
    drain("random");

    // reset after 6 data bytes; remaining FIFO bytes start a fresh frame
    mode = 0;
    for (int b = 0; b < 8; b++) add_byte(8'h50 + 8'(b));
    start = popped_n;
    n = 0;
    while (popped_n - start < 6 && n < 200) begin
      step();
      n++;
    end
    chk("six_pops_before_reset", popped_n - start, 6);
    do_reset();
    add_byte(8'hE1); add_byte(8'hE2);
    add_gap(LONG_GAP);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
